// File: rtl/div4_vector_seq.sv
// div4_vector_seq: W independent lanes of 4-bit / 2-bit unsigned restoring division.
// Latency: out_valid rises 4 cycles after the accepting edge (one quotient bit per cycle, MSB first).
// Backpressure: results are held in DONE until out_ready; in_ready is high only in IDLE,
//   so a new operand set is never taken on the result-handoff edge.
//
// Ports:
//   clk, rst                    clock and asynchronous active-high reset
//   in_valid / in_ready         operand handshake
//   n3..n0 [W]                  dividend bit-planes, lane i = {n3[i],n2[i],n1[i],n0[i]}
//   d1, d0 [W]                  divisor bit-planes, lane i = {d1[i],d0[i]}
//   out_valid / out_ready       result handshake
//   q3..q0 [W], r1, r0 [W]      quotient and remainder bit-planes
//   dz [W]                      per-lane divide-by-zero flag
//
// Build option DIV4_ZERO_SAT_EN: when defined, divide-by-zero lanes report q = 1111 and
// r = low two dividend bits; when undefined they report q = 0000 and r = 00.

module div4_vector_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] n3,
    input  logic [W-1:0] n2,
    input  logic [W-1:0] n1,
    input  logic [W-1:0] n0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q3,
    output logic [W-1:0] q2,
    output logic [W-1:0] q1,
    output logic [W-1:0] q0,
    output logic [W-1:0] r1,
    output logic [W-1:0] r0,
    output logic [W-1:0] dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    logic [1:0]   cnt_q;          // index of the dividend bit consumed this cycle
    logic [W-1:0] n_q [4];        // captured dividend planes, n_q[k] = n_k
    logic [W-1:0] d1_q;
    logic [W-1:0] d0_q;
    logic [W-1:0] rem1_q;
    logic [W-1:0] rem0_q;
    logic [W-1:0] quo_q [4];      // quotient planes, quo_q[k] = q_k
    logic [W-1:0] dz_q;

    // One restoring step for every lane in parallel.
    logic [W-1:0] nbit_d;
    logic [W-1:0] qbit_d;
    logic [W-1:0] rem1_d;
    logic [W-1:0] rem0_d;
    logic [W-1:0] zero_w;
    logic [W-1:0] keep_w;
    logic [2:0]   part;
    logic [2:0]   divs;
    logic [1:0]   nxt;

    assign zero_w = ~(d1_q | d0_q);

    // Lanes whose results survive the final step. With saturation enabled, a zero divisor
    // naturally yields q = 1111 and r = {n1,n0} from the restoring recurrence, so nothing
    // needs masking; otherwise those lanes are forced to zero.
`ifdef DIV4_ZERO_SAT_EN
    assign keep_w = '1;
`else
    assign keep_w = ~zero_w;
`endif

    always_comb begin
        nbit_d = n_q[cnt_q];
        qbit_d = '0;
        rem1_d = '0;
        rem0_d = '0;
        part   = '0;
        divs   = '0;
        nxt    = '0;
        for (int i = 0; i < W; i++) begin
            part = {rem1_q[i], rem0_q[i], nbit_d[i]};
            divs = {1'b0, d1_q[i], d0_q[i]};
            if (part >= divs) begin
                // Fits in 2 bits for any nonzero divisor; for a zero divisor the dropped
                // MSB is exactly the bit shifted out of the saturating remainder.
                nxt       = 2'(part - divs);
                qbit_d[i] = 1'b1;
            end else begin
                nxt       = part[1:0];
                qbit_d[i] = 1'b0;
            end
            rem1_d[i] = nxt[1];
            rem0_d[i] = nxt[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            d1_q    <= '0;
            d0_q    <= '0;
            rem1_q  <= '0;
            rem0_q  <= '0;
            dz_q    <= '0;
            for (int k = 0; k < 4; k++) begin
                n_q[k]   <= '0;
                quo_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        n_q[3] <= n3;
                        n_q[2] <= n2;
                        n_q[1] <= n1;
                        n_q[0] <= n0;
                        d1_q   <= d1;
                        d0_q   <= d0;
                        rem1_q <= '0;
                        rem0_q <= '0;
                        dz_q   <= '0;
                        for (int k = 0; k < 4; k++) begin
                            quo_q[k] <= '0;
                        end
                        cnt_q   <= 2'd3;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd0) begin
                        // Last step: apply the divide-by-zero policy as results are finalised.
                        for (int k = 1; k < 4; k++) begin
                            quo_q[k] <= quo_q[k] & keep_w;
                        end
                        quo_q[0] <= qbit_d & keep_w;
                        rem1_q   <= rem1_d & keep_w;
                        rem0_q   <= rem0_d & keep_w;
                        dz_q     <= zero_w;
                        state_q  <= DONE;
                    end else begin
                        quo_q[cnt_q] <= qbit_d;
                        rem1_q       <= rem1_d;
                        rem0_q       <= rem0_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q3        = quo_q[3];
    assign q2        = quo_q[2];
    assign q1        = quo_q[1];
    assign q0        = quo_q[0];
    assign r1        = rem1_q;
    assign r0        = rem0_q;
    assign dz        = dz_q;

endmodule
